// File: rtl/rob.sv
// -----------------------------------------------------------------------------
// rob : reorder buffer
//
// Circular queue of in-flight instructions. Entries are allocated in program
// order at issue, completed out of order from the CDB, and retired in order
// from the head, at most one per cycle. Commit results go to the register
// file (REG), the store unit (STORE), the fetch redirect (mispredicted
// BRANCH) or stop the machine (EXIT). Operand-readiness queries are answered
// combinationally from entry state.
//
// Optional feature macro: ROB_CDB_BYPASS_EN
//   defined   : a query matching the live CDB tag sees the CDB result at once
//   undefined : queries see entry state only (CDB result visible next cycle)
//
// Ports
//   clk_in, rst_n_in          clock, asynchronous active-low reset
//   rdy_in                    global enable; low freezes all state
//   dec_*_in                  issue request from decode
//   full_out                  no free entry
//   new_dependency_out        tag the next issue receives ({0,tail})
//   cdb_*_in                  execution result broadcast
//   q1/q2_tag_in              operand tags to look up
//   q1/q2_ready_out/value_out lookup result
//   rf_*_out                  registered commit write to register file
//   store_commit_out/tag_out  registered STORE commit
//   need_flush_out/flush_pc   registered misprediction flush and redirect PC
//   halt_out                  EXIT committed (sticky until reset)
// -----------------------------------------------------------------------------
module rob #(
    parameter int ROB_SIZE_WIDTH = 3
) (
    input  logic                      clk_in,
    input  logic                      rst_n_in,
    input  logic                      rdy_in,

    input  logic                      dec_valid_in,
    input  logic [1:0]                dec_type_in,
    input  logic [4:0]                dec_rd_in,
    input  logic                      dec_ready_in,
    input  logic [31:0]               dec_value_in,
    input  logic                      dec_pred_taken_in,
    input  logic [31:0]               dec_alt_pc_in,
    output logic                      full_out,
    output logic [ROB_SIZE_WIDTH:0]   new_dependency_out,

    input  logic                      cdb_valid_in,
    input  logic [ROB_SIZE_WIDTH:0]   cdb_tag_in,
    input  logic [31:0]               cdb_value_in,
    input  logic                      cdb_taken_in,

    input  logic [ROB_SIZE_WIDTH:0]   q1_tag_in,
    input  logic [ROB_SIZE_WIDTH:0]   q2_tag_in,
    output logic                      q1_ready_out,
    output logic                      q2_ready_out,
    output logic [31:0]               q1_value_out,
    output logic [31:0]               q2_value_out,

    output logic                      rf_valid_out,
    output logic [4:0]                rf_rd_out,
    output logic [31:0]               rf_value_out,
    output logic [ROB_SIZE_WIDTH:0]   rf_dependency_out,

    output logic                      store_commit_out,
    output logic [ROB_SIZE_WIDTH:0]   store_tag_out,

    output logic                      need_flush_out,
    output logic [31:0]               flush_pc_out,
    output logic                      halt_out
);

    localparam int                    DEPTH      = 1 << ROB_SIZE_WIDTH;
    localparam logic [ROB_SIZE_WIDTH:0] NO_DEP   = '1;
    localparam logic [ROB_SIZE_WIDTH:0] FULL_CNT = (ROB_SIZE_WIDTH+1)'(DEPTH);

    typedef enum logic [1:0] {
        TYPE_REG    = 2'd0,
        TYPE_STORE  = 2'd1,
        TYPE_BRANCH = 2'd2,
        TYPE_EXIT   = 2'd3
    } rob_type_t;

    logic [DEPTH-1:0]          busy;
    logic [DEPTH-1:0]          ready;
    logic [DEPTH-1:0]          pred;
    logic [DEPTH-1:0]          taken;
    rob_type_t                 kind   [DEPTH];
    logic [4:0]                rd     [DEPTH];
    logic [31:0]               value  [DEPTH];
    logic [31:0]               alt_pc [DEPTH];

    logic [ROB_SIZE_WIDTH-1:0] head;
    logic [ROB_SIZE_WIDTH-1:0] tail;
    logic [ROB_SIZE_WIDTH:0]   count;

    logic                      do_issue;
    logic                      do_commit;
    logic                      do_cdb;
    logic [ROB_SIZE_WIDTH-1:0] cdb_idx;
    logic                      mispredict;

    assign full_out           = (count == FULL_CNT);
    assign new_dependency_out = {1'b0, tail};

    // The flush cycle is dead: the queue is being emptied, so nothing may
    // enter it, complete in it, or leave it.
    assign cdb_idx    = cdb_tag_in[ROB_SIZE_WIDTH-1:0];
    assign do_issue   = dec_valid_in && !full_out && !need_flush_out;
    assign do_cdb     = cdb_valid_in && !cdb_tag_in[ROB_SIZE_WIDTH] &&
                        busy[cdb_idx] && !need_flush_out;
    assign do_commit  = (count != '0) && ready[head] && !halt_out && !need_flush_out;
    assign mispredict = (taken[head] != pred[head]);

    // Operand lookup
    always_comb begin
        q1_ready_out = ready[q1_tag_in[ROB_SIZE_WIDTH-1:0]];
        q1_value_out = value[q1_tag_in[ROB_SIZE_WIDTH-1:0]];
        if (q1_tag_in == NO_DEP) begin
            q1_ready_out = 1'b1;
            q1_value_out = '0;
        end
`ifdef ROB_CDB_BYPASS_EN
        else if (cdb_valid_in && (q1_tag_in == cdb_tag_in)) begin
            q1_ready_out = 1'b1;
            q1_value_out = cdb_value_in;
        end
`endif
    end

    always_comb begin
        q2_ready_out = ready[q2_tag_in[ROB_SIZE_WIDTH-1:0]];
        q2_value_out = value[q2_tag_in[ROB_SIZE_WIDTH-1:0]];
        if (q2_tag_in == NO_DEP) begin
            q2_ready_out = 1'b1;
            q2_value_out = '0;
        end
`ifdef ROB_CDB_BYPASS_EN
        else if (cdb_valid_in && (q2_tag_in == cdb_tag_in)) begin
            q2_ready_out = 1'b1;
            q2_value_out = cdb_value_in;
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            busy              <= '0;
            ready             <= '0;
            pred              <= '0;
            taken             <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                kind[i]   <= TYPE_REG;
                rd[i]     <= '0;
                value[i]  <= '0;
                alt_pc[i] <= '0;
            end
            head              <= '0;
            tail              <= '0;
            count             <= '0;
            rf_valid_out      <= 1'b0;
            rf_rd_out         <= '0;
            rf_value_out      <= '0;
            rf_dependency_out <= NO_DEP;
            store_commit_out  <= 1'b0;
            store_tag_out     <= NO_DEP;
            need_flush_out    <= 1'b0;
            flush_pc_out      <= '0;
            halt_out          <= 1'b0;
        end else if (rdy_in) begin
            rf_valid_out     <= 1'b0;
            store_commit_out <= 1'b0;
            need_flush_out   <= 1'b0;

            if (need_flush_out) begin
                busy  <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (do_cdb) begin
                    ready[cdb_idx] <= 1'b1;
                    value[cdb_idx] <= cdb_value_in;
                    taken[cdb_idx] <= cdb_taken_in;
                end

                // tail is never busy when an issue is accepted, so this
                // cannot collide with the CDB write above.
                if (do_issue) begin
                    busy[tail]   <= 1'b1;
                    ready[tail]  <= dec_ready_in;
                    value[tail]  <= dec_value_in;
                    kind[tail]   <= rob_type_t'(dec_type_in);
                    rd[tail]     <= dec_rd_in;
                    pred[tail]   <= dec_pred_taken_in;
                    taken[tail]  <= dec_pred_taken_in;
                    alt_pc[tail] <= dec_alt_pc_in;
                    tail         <= tail + 1'b1;
                end

                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                    case (kind[head])
                        TYPE_REG: begin
                            rf_valid_out      <= 1'b1;
                            rf_rd_out         <= rd[head];
                            rf_value_out      <= value[head];
                            rf_dependency_out <= {1'b0, head};
                        end
                        TYPE_STORE: begin
                            store_commit_out <= 1'b1;
                            store_tag_out    <= {1'b0, head};
                        end
                        TYPE_BRANCH: begin
                            if (mispredict) begin
                                need_flush_out <= 1'b1;
                                flush_pc_out   <= alt_pc[head];
                            end
                        end
                        default: begin
                            halt_out <= 1'b1;
                        end
                    endcase
                end

                case ({do_issue, do_commit})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rob.sv
module tb_rob;

    localparam logic [3:0] NO_DEP = 4'hF;
`ifdef ROB_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk, rst_n, rdy;
    logic        dec_valid;
    logic [1:0]  dec_type;
    logic [4:0]  dec_rd;
    logic        dec_ready;
    logic [31:0] dec_value;
    logic        dec_pred;
    logic [31:0] dec_alt;
    logic        full;
    logic [3:0]  new_dep;
    logic        cdb_valid;
    logic [3:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        cdb_taken;
    logic [3:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        rf_valid;
    logic [4:0]  rf_rd;
    logic [31:0] rf_value;
    logic [3:0]  rf_dep;
    logic        st_commit;
    logic [3:0]  st_tag;
    logic        need_flush;
    logic [31:0] flush_pc;
    logic        halt;

    rob #(.ROB_SIZE_WIDTH(3)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy),
        .dec_valid_in(dec_valid), .dec_type_in(dec_type), .dec_rd_in(dec_rd),
        .dec_ready_in(dec_ready), .dec_value_in(dec_value),
        .dec_pred_taken_in(dec_pred), .dec_alt_pc_in(dec_alt),
        .full_out(full), .new_dependency_out(new_dep),
        .cdb_valid_in(cdb_valid), .cdb_tag_in(cdb_tag),
        .cdb_value_in(cdb_value), .cdb_taken_in(cdb_taken),
        .q1_tag_in(q1_tag), .q2_tag_in(q2_tag),
        .q1_ready_out(q1_ready), .q2_ready_out(q2_ready),
        .q1_value_out(q1_value), .q2_value_out(q2_value),
        .rf_valid_out(rf_valid), .rf_rd_out(rf_rd), .rf_value_out(rf_value),
        .rf_dependency_out(rf_dep),
        .store_commit_out(st_commit), .store_tag_out(st_tag),
        .need_flush_out(need_flush), .flush_pc_out(flush_pc), .halt_out(halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rdy       = 1'b1;
        dec_valid = 1'b0; dec_type = 2'd0; dec_rd = 5'd0; dec_ready = 1'b0;
        dec_value = 32'd0; dec_pred = 1'b0; dec_alt = 32'd0;
        cdb_valid = 1'b0; cdb_tag = NO_DEP; cdb_value = 32'd0; cdb_taken = 1'b0;
        q1_tag    = NO_DEP; q2_tag = NO_DEP;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic rdy_i,
                         input logic [31:0] v, input logic p, input logic [31:0] alt);
        dec_valid = 1'b1; dec_type = t; dec_rd = r; dec_ready = rdy_i;
        dec_value = v; dec_pred = p; dec_alt = alt;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v, input logic tk);
        cdb_valid = 1'b1; cdb_tag = t; cdb_value = v; cdb_taken = tk;
    endtask

    // ---------------- query table ----------------
    typedef struct {
        bit          cv;
        logic [3:0]  ct;
        logic [31:0] cval;
        logic [3:0]  t1, t2;
        bit          r1;
        logic [31:0] v1;
        bit          r2;
        logic [31:0] v2;
    } qvec_t;
    qvec_t qtab[5];

    // ---------------- reference model ----------------
    typedef struct {
        logic [2:0]  idx;
        logic [1:0]  typ;
        logic [4:0]  rd;
        bit          rdy;
        logic [31:0] val;
        bit          pred;
        bit          taken;
        logic [31:0] alt;
    } rec_t;
    rec_t        mq[$];
    logic [2:0]  m_tail;
    bit          m_flush_pend;
    bit          e_rfv, e_st, e_fl, e_halt;
    logic [4:0]  e_rd;
    logic [31:0] e_rfval, e_flpc;
    logic [3:0]  e_dep, e_sttag;

    task automatic model_reset();
        mq.delete();
        m_tail = 3'd0; m_flush_pend = 1'b0;
        e_rfv = 0; e_st = 0; e_fl = 0; e_halt = 0;
        e_rd = 5'd0; e_rfval = 32'd0; e_flpc = 32'd0;
        e_dep = NO_DEP; e_sttag = NO_DEP;
    endtask

    task automatic model_query(input logic [3:0] t, output bit r, output logic [31:0] v);
        r = 1'b0; v = 32'd0;
        if (t == NO_DEP) begin
            r = 1'b1; v = 32'd0;
        end else if (BYP && cdb_valid && t == cdb_tag) begin
            r = 1'b1; v = cdb_value;
        end else begin
            foreach (mq[i]) if ({1'b0, mq[i].idx} == t) begin r = mq[i].rdy; v = mq[i].val; end
        end
    endtask

    task automatic model_step();
        rec_t h;
        bit   commit, accept;
        if (!rdy) return;
        e_rfv = 0; e_st = 0; e_fl = 0;
        if (m_flush_pend) begin
            mq.delete();
            m_tail = 3'd0;
            m_flush_pend = 1'b0;
            return;
        end
        commit = (mq.size() > 0) && mq[0].rdy && !e_halt;
        accept = dec_valid && (mq.size() < 8);
        if (commit) h = mq[0];
        if (cdb_valid && !cdb_tag[3])
            foreach (mq[i]) if (mq[i].idx == cdb_tag[2:0]) begin
                mq[i].rdy = 1'b1; mq[i].val = cdb_value; mq[i].taken = cdb_taken;
            end
        if (commit) begin
            case (h.typ)
                2'd0: begin e_rfv = 1; e_rd = h.rd; e_rfval = h.val; e_dep = {1'b0, h.idx}; end
                2'd1: begin e_st = 1; e_sttag = {1'b0, h.idx}; end
                2'd2: if (h.taken != h.pred) begin e_fl = 1; e_flpc = h.alt; m_flush_pend = 1; end
                default: e_halt = 1;
            endcase
            void'(mq.pop_front());
        end
        if (accept) begin
            mq.push_back('{idx: m_tail, typ: dec_type, rd: dec_rd, rdy: dec_ready,
                           val: dec_value, pred: dec_pred, taken: dec_pred, alt: dec_alt});
            m_tail = m_tail + 3'd1;
        end
    endtask

    initial begin
        bit          er;
        logic [31:0] ev;
        int          k;

        // ---- reset then idle ----
        do_reset();
        tick();
        chk("rst_rf_valid",   32'(rf_valid),   32'd0);
        chk("rst_store",      32'(st_commit),  32'd0);
        chk("rst_flush",      32'(need_flush), 32'd0);
        chk("rst_halt",       32'(halt),       32'd0);
        chk("rst_rf_dep",     32'(rf_dep),     32'hF);
        chk("rst_store_tag",  32'(st_tag),     32'hF);
        chk("rst_full",       32'(full),       32'd0);
        chk("rst_new_dep",    32'(new_dep),    32'd0);

        // ---- REG commit latency, hold under rdy low ----
        issue(2'd0, 5'd5, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle(); cdb(4'd0, 32'h1234, 1'b0); q1_tag = 4'd0;
        tick();
        idle(); q1_tag = 4'd0; #1;
        chk("reg_q_ready",    32'(q1_ready),   32'd1);
        chk("reg_q_value",    q1_value,        32'h1234);
        chk("reg_not_yet",    32'(rf_valid),   32'd0);
        tick();
        chk("reg_valid",      32'(rf_valid),   32'd1);
        chk("reg_rd",         32'(rf_rd),      32'd5);
        chk("reg_value",      rf_value,        32'h1234);
        chk("reg_dep",        32'(rf_dep),     32'd0);
        rdy = 1'b0;
        tick();
        chk("frozen_pulse",   32'(rf_valid),   32'd1);
        rdy = 1'b1;
        tick();
        chk("pulse_drop",     32'(rf_valid),   32'd0);

        // ---- fill, ignored 9th issue, wrap ----
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(2'd0, 5'(i), 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
            chk("fill_new_dep", 32'(new_dep), 32'((i + 1) % 8));
        end
        chk("fill_full",      32'(full),       32'd1);
        issue(2'd0, 5'd9, 1'b1, 32'h999, 1'b0, 32'd0); q1_tag = 4'd0;
        tick();
        chk("ninth_full",     32'(full),       32'd1);
        chk("ninth_new_dep",  32'(new_dep),    32'd0);
        chk("ninth_ignored",  32'(q1_ready),   32'd0);
        dec_valid = 1'b0; cdb(4'd0, 32'hAA, 1'b0);
        tick();
        cdb_valid = 1'b0; issue(2'd0, 5'd9, 1'b1, 32'h55, 1'b0, 32'd0);
        tick();
        chk("wrap_commit",    32'(rf_valid),   32'd1);
        chk("wrap_commit_v",  rf_value,        32'hAA);
        chk("wrap_commit_d",  32'(rf_dep),     32'd0);
        chk("wrap_not_full",  32'(full),       32'd0);
        chk("wrap_tail_hold", 32'(new_dep),    32'd0);
        tick();
        dec_valid = 1'b0; #1;
        chk("wrap_full",      32'(full),       32'd1);
        chk("wrap_tail",      32'(new_dep),    32'd1);
        chk("wrap_q_ready",   32'(q1_ready),   32'd1);
        chk("wrap_q_value",   q1_value,        32'h55);

        // ---- mispredicted branch flush ----
        do_reset();
        issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h100);
        tick();
        issue(2'd0, 5'd1, 1'b1, 32'h11, 1'b0, 32'd0); cdb(4'd0, 32'd0, 1'b0);
        tick();
        cdb_valid = 1'b0; issue(2'd0, 5'd2, 1'b1, 32'h22, 1'b0, 32'd0);
        tick();
        chk("flush_pulse",    32'(need_flush), 32'd1);
        chk("flush_pc",       flush_pc,        32'h100);
        chk("flush_no_rf",    32'(rf_valid),   32'd0);
        issue(2'd0, 5'd3, 1'b1, 32'h33, 1'b0, 32'd0); cdb(4'd1, 32'h44, 1'b0);
        tick();
        idle();
        chk("flush_one_cyc",  32'(need_flush), 32'd0);
        chk("flush_cyc_norf", 32'(rf_valid),   32'd0);
        chk("flush_new_dep",  32'(new_dep),    32'd0);
        chk("flush_not_full", 32'(full),       32'd0);
        tick();
        chk("flush_empty",    32'(rf_valid),   32'd0);
        issue(2'd0, 5'd3, 1'b1, 32'h77, 1'b0, 32'd0);
        tick();
        idle();
        chk("post_flush_tag", 32'(new_dep),    32'd1);
        tick();
        chk("post_flush_rf",  32'(rf_valid),   32'd1);
        chk("post_flush_dep", 32'(rf_dep),     32'd0);
        chk("post_flush_val", rf_value,        32'h77);
        issue(2'd2, 5'd0, 1'b0, 32'd0, 1'b1, 32'h200);
        tick();
        idle(); cdb(4'd1, 32'd0, 1'b1);
        tick();
        idle();
        tick();
        chk("good_branch",    32'(need_flush), 32'd0);
        chk("good_branch_rf", 32'(rf_valid),   32'd0);
        chk("good_branch_nd", 32'(new_dep),    32'd2);

        // ---- out-of-order completion ----
        do_reset();
        issue(2'd0, 5'd1, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        issue(2'd0, 5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle(); cdb(4'd1, 32'd11, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("ooo_wait", 32'(rf_valid), 32'd0);
        end
        cdb(4'd0, 32'd10, 1'b0);
        tick();
        idle();
        chk("ooo_still_wait", 32'(rf_valid),   32'd0);
        tick();
        chk("ooo_c0",         32'(rf_valid),   32'd1);
        chk("ooo_c0_dep",     32'(rf_dep),     32'd0);
        chk("ooo_c0_val",     rf_value,        32'd10);
        tick();
        chk("ooo_c1",         32'(rf_valid),   32'd1);
        chk("ooo_c1_dep",     32'(rf_dep),     32'd1);
        chk("ooo_c1_val",     rf_value,        32'd11);
        tick();
        chk("ooo_done",       32'(rf_valid),   32'd0);

        // ---- query table (state frozen with rdy low) ----
        do_reset();
        issue(2'd0, 5'd1, 1'b1, 32'h10, 1'b0, 32'd0);
        tick();
        issue(2'd0, 5'd2, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        issue(2'd0, 5'd3, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle();
        rdy = 1'b0;
        qtab[0] = '{cv:0, ct:NO_DEP, cval:0, t1:4'd0, t2:4'd1, r1:1, v1:32'h10, r2:0, v2:0};
        qtab[1] = '{cv:0, ct:NO_DEP, cval:0, t1:NO_DEP, t2:4'd0, r1:1, v1:0, r2:1, v2:32'h10};
        qtab[2] = '{cv:1, ct:4'd2, cval:32'd7, t1:4'd2, t2:NO_DEP, r1:BYP, v1:32'd7, r2:1, v2:0};
        qtab[3] = '{cv:1, ct:4'd1, cval:32'd9, t1:4'd1, t2:4'd2, r1:BYP, v1:32'd9, r2:0, v2:0};
        qtab[4] = '{cv:0, ct:NO_DEP, cval:0, t1:4'd1, t2:4'd2, r1:0, v1:0, r2:0, v2:0};
        for (int i = 0; i < 5; i++) begin
            cdb_valid = qtab[i].cv; cdb_tag = qtab[i].ct; cdb_value = qtab[i].cval;
            q1_tag = qtab[i].t1; q2_tag = qtab[i].t2;
            #1;
            chk($sformatf("qtab%0d_r1", i), 32'(q1_ready), 32'(qtab[i].r1));
            if (qtab[i].r1) chk($sformatf("qtab%0d_v1", i), q1_value, qtab[i].v1);
            chk($sformatf("qtab%0d_r2", i), 32'(q2_ready), 32'(qtab[i].r2));
            if (qtab[i].r2) chk($sformatf("qtab%0d_v2", i), q2_value, qtab[i].v2);
            tick();
        end
        rdy = 1'b1;
        cdb(4'd2, 32'd7, 1'b0); q1_tag = 4'd2; #1;
        chk("bypass_ready",   32'(q1_ready),   32'(BYP));
        if (BYP) chk("bypass_value", q1_value, 32'd7);
        tick();
        cdb_valid = 1'b0; #1;
        chk("late_ready",     32'(q1_ready),   32'd1);
        chk("late_value",     q1_value,        32'd7);

        // ---- STORE commit then EXIT halt ----
        do_reset();
        issue(2'd1, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        tick();
        issue(2'd3, 5'd0, 1'b1, 32'd0, 1'b0, 32'd0);
        tick();
        chk("store_pulse",    32'(st_commit),  32'd1);
        chk("store_tag",      32'(st_tag),     32'd0);
        chk("store_no_rf",    32'(rf_valid),   32'd0);
        issue(2'd0, 5'd4, 1'b1, 32'h5, 1'b0, 32'd0);
        tick();
        idle();
        chk("exit_halt",      32'(halt),       32'd1);
        chk("exit_store_low", 32'(st_commit),  32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_no_commit", 32'(rf_valid), 32'd0);
            chk("halt_sticky",    32'(halt),     32'd1);
        end

        // ---- randomized run against the queue model ----
        do_reset();
        model_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rdy       = ($urandom_range(0, 9) != 0);
            dec_valid = ($urandom_range(0, 2) != 0);
            dec_type  = 2'($urandom_range(0, 2));
            dec_ready = (dec_type != 2'd2) && ($urandom_range(0, 2) == 0);
            dec_rd    = 5'($urandom);
            dec_value = $urandom;
            dec_pred  = 1'($urandom);
            dec_alt   = $urandom;
            cdb_valid = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, mq.size() - 1);
                cdb_tag = {1'b0, mq[k].idx};
            end else begin
                cdb_tag = 4'($urandom);
            end
            cdb_value = $urandom;
            cdb_taken = 1'($urandom);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, mq.size() - 1);
                q1_tag = {1'b0, mq[k].idx};
            end else q1_tag = NO_DEP;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
                k = $urandom_range(0, mq.size() - 1);
                q2_tag = {1'b0, mq[k].idx};
            end else q2_tag = NO_DEP;
            #1;
            chk("rnd_full",    32'(full),    32'(mq.size() == 8));
            chk("rnd_new_dep", 32'(new_dep), 32'({1'b0, m_tail}));
            model_query(q1_tag, er, ev);
            chk("rnd_q1_ready", 32'(q1_ready), 32'(er));
            if (er) chk("rnd_q1_value", q1_value, ev);
            model_query(q2_tag, er, ev);
            chk("rnd_q2_ready", 32'(q2_ready), 32'(er));
            if (er) chk("rnd_q2_value", q2_value, ev);
            model_step();
            tick();
            chk("rnd_rf_valid", 32'(rf_valid),   32'(e_rfv));
            chk("rnd_rf_rd",    32'(rf_rd),      32'(e_rd));
            chk("rnd_rf_value", rf_value,        e_rfval);
            chk("rnd_rf_dep",   32'(rf_dep),     32'(e_dep));
            chk("rnd_store",    32'(st_commit),  32'(e_st));
            chk("rnd_st_tag",   32'(st_tag),     32'(e_sttag));
            chk("rnd_flush",    32'(need_flush), 32'(e_fl));
            chk("rnd_flush_pc", flush_pc,        e_flpc);
            chk("rnd_halt",     32'(halt),       32'(e_halt));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
